md_sched: RTL and testbench

- Sequencing controller for the multi-cycle multiply/divide unit in the execute stage.
- Accepts mult/multu/div/divu issue from E and pulses the unit's start.
- Tracks operation latency with a down-counter and produces the D-stage stall for any HI/LO-dependent instruction.
- Cancels a just-issued operation on pipeline flush by suppressing start or driving rollback.

---
 rtl/md_sched_pkg.sv | 21 ++
 rtl/md_sched_lat_cnt.sv | 45 ++++
 rtl/md_sched.sv | 131 +++++++++++++
 tb/tb_md_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// md_sched_pkg
// Shared definitions for the multiply/divide sequencing controller:
// FSM state encodings, XALU opcode constants and default latencies.
package md_sched_pkg;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_RUN  = 2'd1,
        MDS_DONE = 2'd2
    } mds_state_e;

    localparam logic [3:0] XALU_MULT  = 4'b0000;
    localparam logic [3:0] XALU_MULTU = 4'b0001;
    localparam logic [3:0] XALU_DIV   = 4'b0010;
    localparam logic [3:0] XALU_DIVU  = 4'b0011;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/md_sched_lat_cnt.sv
// md_lat_cnt
// Loadable down-counter that times the multi-cycle operation.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low clear
//   i_clr      synchronous clear (highest priority)
//   i_load     load i_load_val
//   i_load_val value loaded on i_load
//   i_dec      decrement by one (saturates at zero)
//   o_value    current count
//   o_zero     count is zero
//   o_one      count is one (last busy cycle)
module md_lat_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero,
    output logic             o_one
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);
    assign o_one   = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/md_sched.sv
// md_sched
// Sequencing controller for the multi-cycle multiply/divide unit (XALU)
// in the execute stage. Issues the start pulse, times the operation,
// stalls HI/LO users in D and cancels a just-issued op on flush.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation pending; a new op may be accepted
// RUN   | XALU busy; counter holds remaining busy cycles
// DONE  | one cycle, result valid in HI/LO; back-to-back issue allowed
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   start_E       mult/multu/div/divu valid in E this cycle
//   op_E          00 mult, 01 multu, 10 div, 11 divu
//   use_D         D-stage instruction touches HI/LO
//   flush         pipeline flush this cycle
//   xalu_start    combinational start pulse to XALU
//   xalu_op       XALU opcode (op_E zero-extended)
//   xalu_rollback XALU restores previous HI/LO
//   busy          operation in progress
//   done          result valid pulse
//   stall_D       freeze F/D and bubble E
//   proto_err     sticky: start_E seen while RUN
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_E,
    input  logic [1:0] op_E,
    input  logic       use_D,
    input  logic       flush,
    output logic       xalu_start,
    output logic [3:0] xalu_op,
    output logic       xalu_rollback,
    output logic       busy,
    output logic       done,
    output logic       stall_D,
    output logic       proto_err
);

    localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);

    mds_state_e r_state;
    logic       r_fresh;
    logic       r_proto_err;

    logic             w_run;
    logic             w_acc;
    logic             w_rollback;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;
    logic             w_cnt_one;

    assign w_run      = (r_state == MDS_RUN);
    assign w_acc      = start_E & ~flush & ~w_run;
    // Only an op issued in the previous cycle is still cancellable.
    assign w_rollback = w_run & r_fresh & flush;
    assign w_load_val = op_E[1] ? DIV_LAT_C : MULT_LAT_C;

    md_lat_cnt #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .i_clr      (w_rollback),
        .i_load     (w_acc),
        .i_load_val (w_load_val),
        .i_dec      (w_run),
        .o_value    (w_cnt),
        .o_zero     (w_cnt_zero),
        .o_one      (w_cnt_one)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= MDS_IDLE;
            r_fresh     <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_fresh <= w_acc;
            if (start_E && w_run) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                MDS_IDLE: begin
                    if (w_acc) begin
                        r_state <= MDS_RUN;
                    end
                end
                MDS_RUN: begin
                    if (w_rollback) begin
                        r_state <= MDS_IDLE;
                    end else if (w_cnt_one) begin
                        r_state <= MDS_DONE;
                    end
                end
                MDS_DONE: begin
                    r_state <= w_acc ? MDS_RUN : MDS_IDLE;
                end
                default: begin
                    r_state <= MDS_IDLE;
                end
            endcase
        end
    end

    // Combinational outputs are gated by reset so every output is quiet
    // while reset is held, even with start_E/use_D active.
    assign xalu_start    = w_acc & reset;
    assign xalu_op       = reset ? {2'b00, op_E} : 4'b0000;
    assign xalu_rollback = w_rollback;
    assign busy          = w_run;
    assign done          = (r_state == MDS_DONE);
    assign stall_D       = use_D & (w_run | w_acc) & reset;
    assign proto_err     = r_proto_err;

    // Counter value/zero flag are kept for observability; the FSM only
    // needs the last-busy-cycle flag.
    logic w_unused;
    assign w_unused = ^{w_cnt, w_cnt_zero};

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;

    logic       clk;
    logic       reset;
    logic       start_E;
    logic [1:0] op_E;
    logic       use_D;
    logic       flush;
    logic       xalu_start;
    logic [3:0] xalu_op;
    logic       xalu_rollback;
    logic       busy;
    logic       done;
    logic       stall_D;
    logic       proto_err;

    md_sched dut (
        .clk           (clk),
        .reset         (reset),
        .start_E       (start_E),
        .op_E          (op_E),
        .use_D         (use_D),
        .flush         (flush),
        .xalu_start    (xalu_start),
        .xalu_op       (xalu_op),
        .xalu_rollback (xalu_rollback),
        .busy          (busy),
        .done          (done),
        .stall_D       (stall_D),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: an op is described by its issue cycle and latency;
    // busy/done/rollback follow from plain cycle arithmetic.
    int   cyc      = 0;
    bit   m_active = 0;
    int   m_iss    = 0;
    int   m_lat    = 0;
    bit   m_proto  = 0;
    logic [9:0] exp_v;
    logic [9:0] obs;

    assign obs = {xalu_start, xalu_op, xalu_rollback, busy, done, stall_D, proto_err};

    task automatic model_clear();
        m_active = 0;
        m_proto  = 0;
    endtask

    // Drives one cycle of inputs, computes the expected outputs for this
    // cycle and advances the model across the coming edge.
    task automatic drive(input bit s, input logic [1:0] o, input bit u, input bit f);
        bit run, dn, acc, rb, stl;
        @(negedge clk);
        start_E = s; op_E = o; use_D = u; flush = f;
        run = m_active && (cyc > m_iss) && (cyc <= m_iss + m_lat);
        dn  = m_active && (cyc == m_iss + m_lat + 1);
        acc = s && !f && !run;
        rb  = run && (cyc == m_iss + 1) && f;
        stl = u && (run || acc);
        exp_v = {acc, 2'b00, o, rb, run, dn, stl, m_proto};
        if (s && run) m_proto = 1;
        if (rb) m_active = 0;
        if (acc) begin
            m_active = 1;
            m_iss    = cyc;
            m_lat    = o[1] ? 10 : 5;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start_E = 1'b1; op_E = 2'b11; use_D = 1'b1; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== 10'b0) begin
                failures++;
                $display("FAIL reset_hold got=%b exp=%b", obs, 10'b0);
            end
        end
        start_E = 1'b0; use_D = 1'b0; op_E = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (obs !== 10'b0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", obs, 10'b0);
        end
    endtask

    task automatic test_mult();
        int busy_cnt = 0;
        int done_at  = -1;
        for (int k = 0; k < 8; k++) begin
            drive(k == 0, 2'b00, 0, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL mult k=%0d got=%b exp=%b", k, obs, exp_v);
            end
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = k;
        end
        checks++;
        if (busy_cnt !== 5 || done_at !== 6) begin
            failures++;
            $display("FAIL mult_latency busy_cnt=%0d done_at=%0d exp 5/6", busy_cnt, done_at);
        end
    endtask

    task automatic test_stall_divu();
        for (int k = 0; k < 12; k++) begin
            drive(k == 0, 2'b11, 1, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL stall_divu k=%0d got=%b exp=%b", k, obs, exp_v);
            end
            if (k <= 10) begin
                checks++;
                if (stall_D !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_divu_hold k=%0d got=%b exp=1", k, stall_D);
                end
            end else begin
                checks++;
                if (stall_D !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_divu_release stall=%b busy=%b done=%b exp 0/0/1", stall_D, busy, done);
                end
            end
        end
    endtask

    task automatic test_flush_same();
        bit seen_done = 0;
        for (int k = 0; k < 13; k++) begin
            drive(k == 0, 2'b10, 0, k == 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL flush_same k=%0d got=%b exp=%b", k, obs, exp_v);
            end
            if (done || busy) seen_done = 1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL flush_same_activity got=%b exp=0", seen_done);
        end
    endtask

    task automatic test_rollback();
        for (int k = 0; k < 5; k++) begin
            drive(k == 0, 2'b10, 0, k == 1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL rollback k=%0d got=%b exp=%b", k, obs, exp_v);
            end
            if (k == 1) begin
                checks++;
                if (xalu_rollback !== 1'b1) begin
                    failures++;
                    $display("FAIL rollback_pulse got=%b exp=1", xalu_rollback);
                end
            end
        end
        // Late flush on a new op must not cancel it.
        for (int k = 0; k < 13; k++) begin
            drive(k == 0, 2'b10, 0, k == 3);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL late_flush k=%0d got=%b exp=%b", k, obs, exp_v);
            end
            if (k == 11) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL late_flush_done got=%b exp=1", done);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 19; k++) begin
            drive(k == 0 || k == 6 || k == 8, (k == 0) ? 2'b00 : ((k == 6) ? 2'b10 : 2'b01),
                  0, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL b2b k=%0d got=%b exp=%b", k, obs, exp_v);
            end
            if (k == 6) begin
                checks++;
                if (xalu_start !== 1'b1 || done !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_issue start=%b done=%b exp 1/1", xalu_start, done);
                end
            end
            if (k == 17) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_done got=%b exp=1", done);
                end
            end
        end
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL proto_err_sticky got=%b exp=1", proto_err);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            drive(k == 0, 2'b10, 1, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL areset_pre k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
        @(negedge clk);
        #2;
        start_E = 1'b1; use_D = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0) begin
            failures++;
            $display("FAIL areset_immediate got=%b exp=%b", obs, 10'b0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== 10'b0) begin
                failures++;
                $display("FAIL areset_hold got=%b exp=%b", obs, 10'b0);
            end
        end
        start_E = 1'b0; use_D = 1'b0; op_E = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        for (int k = 0; k < 8; k++) begin
            drive(k == 0, 2'b01, 0, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL areset_post k=%0d got=%b exp=%b", k, obs, exp_v);
            end
            if (k == 6) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL areset_post_done got=%b exp=1", done);
                end
            end
        end
    endtask

    task automatic test_random();
        bit s, u, f;
        logic [1:0] o;
        for (int k = 0; k < 400; k++) begin
            s = ($urandom_range(0, 9) < 3);
            o = 2'($urandom_range(0, 3));
            u = $urandom_range(0, 1) == 1;
            f = ($urandom_range(0, 9) == 0);
            drive(s, o, u, f);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start_E = 1'b0; op_E = 2'b00; use_D = 1'b0; flush = 1'b0;
        test_reset();
        test_mult();
        test_stall_divu();
        test_flush_same();
        test_rollback();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
